// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scanner with per-frame snapshot of the digit codes.
// Optional build macro SEG_BLINK_EN adds a live per-digit blink mask driven by a slow tick phase.
module seg_scan_driver #(
    parameter int SCAN_DIV_W = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] dig0,
    input  logic [3:0] dig1,
    input  logic [3:0] dig2,
    input  logic [3:0] dig3,
`ifdef SEG_BLINK_EN
    input  logic [3:0] blink,
`endif
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam logic [SCAN_DIV_W-1:0] CNT_ONE = 1;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [SCAN_DIV_W-1:0] div_cnt;
    logic                  tick;
    logic [1:0]            idx;
    logic [3:0]            snap0, snap1, snap2, snap3;
    logic [3:0]            cur_code;
    logic                  blank_now;

    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            4'd11:   decode = 7'b0111111;
            default: decode = SEG_BLANK;
        endcase
    endfunction

    assign tick = &div_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CNT_ONE;
        end
    end

    // Snapshots load only on the 3->0 wrap so a whole frame shows one consistent set of codes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= 2'd0;
            snap0 <= 4'd10;
            snap1 <= 4'd10;
            snap2 <= 4'd10;
            snap3 <= 4'd10;
        end else if (tick) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
                snap0 <= dig0;
                snap1 <= dig1;
                snap2 <= dig2;
                snap3 <= dig3;
            end
        end
    end

    always_comb begin
        cur_code = snap0;
        case (idx)
            2'd0: cur_code = snap0;
            2'd1: cur_code = snap1;
            2'd2: cur_code = snap2;
            2'd3: cur_code = snap3;
            default: cur_code = snap0;
        endcase
    end

`ifdef SEG_BLINK_EN
    logic [5:0] blink_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= 6'd0;
        end else if (tick) begin
            blink_cnt <= blink_cnt + 6'd1;
        end
    end

    // Blink mask is applied live so the caller can toggle it without waiting for a frame wrap.
    assign blank_now = blink_cnt[5] & blink[idx];
`else
    assign blank_now = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= blank_now ? SEG_BLANK : decode(cur_code);
        end
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have parameter SCAN_DIV_W, default 17: prescaler width; one scan tick every 2^SCAN_DIV_W clk cycles.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 The block SHALL have ports dig0, dig1, dig2, dig3, input, 4 each: digit codes from the game FSM; dig0 = rightmost, dig3 = leftmost.
REQ-005 The block SHALL have port an, output, 4: digit enables, active-low; an[i] selects digit i.
REQ-006 The block SHALL have port seg, output, 7: segment drive, active-low, bit order {g,f,e,d,c,b,a}.

Function
REQ-007 The prescaler SHALL be a SCAN_DIV_W-bit free-running up-counter that wraps to 0; tick = 1 in the cycle the counter equals all-ones.
REQ-008 The scan index idx SHALL be 2 bits and advance 0->1->2->3->0 on each tick; it holds otherwise.
REQ-009 On the tick where idx = 3, the snapshot registers snap0..snap3 SHALL load dig0..dig3 at the same edge that idx becomes 0; they hold at all other times, so each frame is tear-free.
REQ-010 an and seg SHALL be registered: in every cycle they load the decode of the current idx and the current snapshot, so they lag idx and snapshot by exactly 1 clk.
REQ-011 an SHALL have exactly one bit low: bit idx.
REQ-012 The decode SHALL map codes 0-9 to the standard digits: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-013 The decode SHALL map code 10 to blank (1111111), code 11 to dash (0111111, g only), and codes 12-15 to blank.
REQ-014 Input changes mid-frame SHALL NOT affect outputs until the next idx 3->0 wrap; if inputs change in the same cycle as the wrap tick, the new values SHALL be captured.
REQ-015 No handshake SHALL exist; inputs are sampled only at the wrap point and need not be held otherwise.

Reset
REQ-016 While rst_n = 0, the prescaler SHALL be 0, idx SHALL be 0, snap0..snap3 SHALL be 4'd10, an SHALL be 4'b1111 (all off), and seg SHALL be 7'b1111111.
REQ-017 Reset assertion SHALL take effect immediately, without a clock edge, including mid-frame or mid-tick.
REQ-018 After deassertion, the first clk edge SHALL drive an = 4'b1110 and seg = blank.
REQ-019 The first snapshot of real inputs SHALL occur at the first idx 3->0 wrap, 4*2^SCAN_DIV_W cycles after release.

Configuration
REQ-020 When macro SEG_BLINK_EN is defined, the block SHALL add input port blink, 4 bits (blink[i] applies to digit i).
REQ-021 When SEG_BLINK_EN is defined, the block SHALL add a 6-bit tick counter that resets to 0, with blink phase = bit 5 of that counter.
REQ-022 When SEG_BLINK_EN is defined, a digit SHALL be decoded as blank whenever phase = 1 and blink[idx] = 1; blink is sampled live, not snapshotted.
REQ-023 When SEG_BLINK_EN is not defined, the blink port and tick counter SHALL be absent, and behaviour SHALL be exactly REQ-007 to REQ-019.

Verification (SCAN_DIV_W = 2, tick every 4 cycles)
REQ-024 Reset check: hold rst_n = 0, then release -> an = 1111 and seg = 1111111 during reset; an = 1110 and seg = 1111111 one cycle after release; all four digits blank for the first frame.
REQ-025 Frame check: dig3..dig0 = 1,2,3,4 before the first wrap -> next frame shows an 1110/0011001, 1101/0110000, 1011/0100100, 0111/1111001, with each slot 4 cycles long.
REQ-026 Tear-free check: change dig0 from 4 to 7 while idx = 1 -> digit 0 still shows 0011001 until after the next wrap, then shows 1111000.
REQ-027 Code check: dig = 10, 11, 15, 8 -> seg = 1111111, 0111111, 1111111, 0000000 on digits 0-3 respectively.
REQ-028 Reset mid-frame: assert rst_n = 0 while idx = 2 -> an = 1111 within the same cycle, without a clock edge; the snapshot returns to blank.
REQ-029 Blink check (SEG_BLINK_EN defined): blink = 0001 and dig0 = 5 -> digit 0 shows 0010010 for 32 ticks and blank for the next 32 ticks, repeating; digits 1-3 are unaffected.
